// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: data + control bus under valid/ready, optional 2-entry skid.
// Latency: 1 cycle from in_fire to out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: SKID=1 registered in_ready (= skid entry free); SKID=0 in_ready = out_ready | ~out_valid.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of every stored entry (beats on the input are dropped)
//   bubble            on a captured beat, ctrl bits set in KILL_MASK are forced to 0
//   in_valid/in_ready/in_data/in_ctrl       upstream handshake and payload
//   out_valid/out_ready/out_data/out_ctrl   downstream handshake and head-entry payload
//   occupancy         number of stored entries (0..2, at most 1 when SKID=0)
module pipe_stage_reg #(
    parameter int                DATA_W     = 96,
    parameter int                CTRL_W     = 16,
    parameter logic [CTRL_W-1:0] KILL_MASK  = {CTRL_W{1'b1}},
    parameter bit                SKID       = 1'b1,
    parameter bit                FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_dat;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_dat;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic              w_main_vld;
    logic              w_skid_vld;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CTRL_W-1:0] w_cap_ctrl;

    // Valid bits are decoded straight from the state register, so in_ready
    // in the skid configuration is a pure register output.
    assign w_main_vld = (r_state != ST_EMPTY);
    assign w_skid_vld = (r_state == ST_FULL);

    assign in_ready   = SKID ? ~w_skid_vld : (out_ready | ~w_main_vld);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_vld & out_ready;

    // Bubble only touches control; the data bus passes untouched.
    assign w_cap_ctrl = bubble ? (in_ctrl & ~KILL_MASK) : in_ctrl;

    assign out_valid  = w_main_vld;
    assign out_data   = r_main_dat;
    assign out_ctrl   = r_main_ctrl;
    assign occupancy  = {1'b0, w_main_vld} + {1'b0, w_skid_vld};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_dat  <= '0;
            r_main_ctrl <= '0;
            r_skid_dat  <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Flush wins over any load; a beat leaving this cycle was already
            // sampled downstream, so nothing else needs to happen for it.
            r_state <= ST_EMPTY;
            if (FLUSH_ZERO) begin
                r_main_dat  <= '0;
                r_main_ctrl <= '0;
                r_skid_dat  <= '0;
                r_skid_ctrl <= '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_dat  <= in_data;
                        r_main_ctrl <= w_cap_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    // Without the skid an accepted beat always coincides with
                    // out_fire (in_ready needs out_ready), so the first branch
                    // covers every SKID=0 load from this state.
                    if (w_in_fire && w_out_fire) begin
                        r_main_dat  <= in_data;
                        r_main_ctrl <= w_cap_ctrl;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end else if (w_in_fire) begin
                        r_skid_dat  <= in_data;
                        r_skid_ctrl <= w_cap_ctrl;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main_dat  <= r_skid_dat;
                        r_main_ctrl <= r_skid_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (SKID=1, FLUSH_ZERO=1) and one
// single-register instance (SKID=0, FLUSH_ZERO=0) share stimulus; each is
// compared every cycle against its own FIFO-array reference model.
module tb_pipe_stage_reg;

    localparam int            DW = 96;
    localparam int            CW = 16;
    localparam logic [CW-1:0] KM = 16'h0003;

    logic          clk = 1'b0;
    logic          reset, flush, bubble, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [1:0]    s_occ;

    logic          n_in_ready, n_out_valid;
    logic [DW-1:0] n_out_data;
    logic [CW-1:0] n_out_ctrl;
    logic [1:0]    n_occ;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KM), .SKID(1'b1), .FLUSH_ZERO(1'b1)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KM), .SKID(1'b0), .FLUSH_ZERO(1'b0)) u_dut_single (
        .clk(clk), .reset(reset), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .occupancy(n_occ)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Model index 1 = skid instance (capacity 2, flush zeroes), 0 = single (capacity 1, flush retains).
    ent_t mem  [2][2];
    int   cnt  [2];
    ent_t disp [2];   // value shown on the outputs while the stage is empty
    bit   def  [2];   // whether that empty-stage value is pinned down (after reset/flush)

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int i);
        if (i == 1) return (cnt[1] < 2);
        return (cnt[0] == 0) || out_ready;
    endfunction

    task automatic check_one(input int i, input string nm, input logic vld, input logic rdy,
                             input logic [1:0] occ, input logic [DW-1:0] d, input logic [CW-1:0] c);
        ent_t e;
        e = (cnt[i] > 0) ? mem[i][0] : disp[i];
        chk({nm, "_out_valid"}, 128'(vld), 128'(cnt[i] > 0));
        chk({nm, "_in_ready"},  128'(rdy), 128'(exp_rdy(i)));
        chk({nm, "_occupancy"}, 128'(occ), 128'(cnt[i]));
        if (cnt[i] > 0 || def[i]) begin
            chk({nm, "_out_data"}, 128'(d), 128'(e.d));
            chk({nm, "_out_ctrl"}, 128'(c), 128'(e.c));
        end
    endtask

    task automatic check_all();
        check_one(1, "skid",   s_out_valid, s_in_ready, s_occ, s_out_data, s_out_ctrl);
        check_one(0, "single", n_out_valid, n_in_ready, n_occ, n_out_data, n_out_ctrl);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i]  = 0;
            disp[i] = '0;
            def[i]  = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit   inf, outf, od;
            ent_t oh, ne;
            inf  = in_valid && exp_rdy(i);
            outf = (cnt[i] > 0) && out_ready;
            oh   = (cnt[i] > 0) ? mem[i][0] : disp[i];
            od   = (cnt[i] > 0) || def[i];
            if (flush) begin
                cnt[i] = 0;
                if (i == 1) begin
                    disp[i] = '0;
                    def[i]  = 1'b1;
                end else begin
                    disp[i] = oh;
                    def[i]  = od;
                end
            end else begin
                if (outf) begin
                    mem[i][0] = mem[i][1];
                    cnt[i]--;
                end
                if (inf && cnt[i] < 2) begin
                    ne.d = in_data;
                    ne.c = bubble ? (in_ctrl & ~KM) : in_ctrl;
                    mem[i][cnt[i]] = ne;
                    cnt[i]++;
                end
                if (cnt[i] > 0) begin
                    disp[i] = mem[i][0];
                    def[i]  = 1'b1;
                end else begin
                    def[i] = 1'b0;
                end
            end
        end
    endtask

    // Check at the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic b);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        bubble   = b;
        flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        model_reset();
        step();
        step();
        reset = 1'b0;

        // Test 1: fill to two entries, then assert reset between clock edges.
        out_ready = 1'b0;
        beat(96'h11, 16'h0011, 1'b0); step();
        beat(96'h22, 16'h0022, 1'b0); step();
        idle();
        chk("t1_pre_occ", 128'(s_occ), 128'(2));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_vld",  128'(s_out_valid), 128'(0));
        chk("t1_rst_ctrl", 128'(s_out_ctrl),  128'(0));
        chk("t1_rst_occ",  128'(s_occ),       128'(0));
        chk("t1_rst_rdy",  128'(s_in_ready),  128'(1));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        beat(96'h1234, 16'h0000, 1'b0); step();
        idle();
        chk("t1_first_vld",  128'(s_out_valid), 128'(1));
        chk("t1_first_data", 128'(s_out_data),  128'(96'h1234));
        step();

        // Test 2: back-to-back streaming with out_ready high.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            beat(DW'(k), CW'(k), 1'b0);
            step();
            chk("t2_stream_data", 128'(s_out_data), 128'(k));
            chk("t2_stream_occ",  128'(s_occ),      128'(1));
        end
        idle(); step(); step();

        // Test 3: backpressure with A, B, C.
        out_ready = 1'b0;
        beat(96'hA, 16'h000A, 1'b0); step();
        beat(96'hB, 16'h000B, 1'b0); step();
        chk("t3_rdy_low", 128'(s_in_ready), 128'(0));
        chk("t3_hold_a",  128'(s_out_data), 128'(96'hA));
        beat(96'hC, 16'h000C, 1'b0); step();
        chk("t3_still_a", 128'(s_out_data), 128'(96'hA));
        out_ready = 1'b1;
        step();
        chk("t3_then_b", 128'(s_out_data), 128'(96'hB));
        step();
        chk("t3_then_c", 128'(s_out_data), 128'(96'hC));
        idle(); step(); step();

        // Test 4: bubble masks the low two control bits only.
        out_ready = 1'b1;
        beat(96'h5A5A, 16'hFFFF, 1'b1); step();
        chk("t4_bubble_ctrl", 128'(s_out_ctrl), 128'(16'hFFFC));
        chk("t4_bubble_data", 128'(s_out_data), 128'(96'h5A5A));
        beat(96'h6B6B, 16'hFFFF, 1'b0); step();
        chk("t4_plain_ctrl", 128'(s_out_ctrl), 128'(16'hFFFF));
        idle(); step();

        // Test 5: flush while full with a simultaneous incoming beat.
        out_ready = 1'b0;
        beat(96'h51, 16'h0051, 1'b0); step();
        beat(96'h52, 16'h0052, 1'b0); step();
        beat(96'h53, 16'h0053, 1'b0); flush = 1'b1; step();
        idle();
        chk("t5_flush_vld",  128'(s_out_valid), 128'(0));
        chk("t5_flush_data", 128'(s_out_data),  128'(0));
        chk("t5_flush_occ",  128'(s_occ),       128'(0));
        chk("t5_flush_rdy",  128'(s_in_ready),  128'(1));
        step(); step();

        // Test 6: single-register instance, combinational ready, retaining flush.
        out_ready = 1'b0;
        beat(96'h61, 16'h0061, 1'b0); step();
        beat(96'h62, 16'h0062, 1'b0);
        #1 chk("t6_rdy_low", 128'(n_in_ready), 128'(0));
        out_ready = 1'b1;
        #1 chk("t6_rdy_comb", 128'(n_in_ready), 128'(1));
        step();
        chk("t6_loaded", 128'(n_out_data), 128'(96'h62));
        idle(); out_ready = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        chk("t6_flush_vld",  128'(n_out_valid), 128'(0));
        chk("t6_flush_keep", 128'(n_out_data),  128'(96'h62));
        step();

        // Randomised traffic with occasional flush and asynchronous reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(99) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            flush     = ($urandom_range(19) == 0);
            in_valid  = ($urandom_range(9) < 7);
            bubble    = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(9) < 6);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = CW'($urandom);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
